// File: rtl/rf_cfg_pkg.sv
// Shared opcodes, result codes, frame lengths and FSM encoding for the
// mode-3 configuration initiator.
package rf_cfg_pkg;

   localparam logic [1:0] OP_WRITE  = 2'd0;
   localparam logic [1:0] OP_RD_CFG = 2'd1;
   localparam logic [1:0] OP_RD_VER = 2'd2;
   localparam logic [1:0] OP_RESET  = 2'd3;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_AUX      = 2'd1;
   localparam logic [1:0] ERR_RESP     = 2'd2;
   localparam logic [1:0] ERR_MISMATCH = 2'd3;

   localparam logic [2:0] LEN_WRITE    = 3'd6;
   localparam logic [2:0] LEN_CMD      = 3'd3;
   localparam logic [2:0] LEN_RESP_CFG = 3'd6;
   localparam logic [2:0] LEN_RESP_VER = 3'd4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ENTER,
      ST_AUX_WAIT,
      ST_SEND,
      ST_RESP,
      ST_CHECK,
      ST_EXIT,
      ST_EXIT_WAIT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/rf_cfg_timeout.sv
// Loadable saturating down-counter; expired_o is high once the count reaches zero.
module rf_cfg_timeout #(
   parameter int unsigned MAX = 65535
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = W'(MAX);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= W'(MAX);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rf_config_master.sv
// Host-side initiator for the transceiver mode-3 configuration protocol.
// Define RF_CFG_VERIFY_EN to follow every write with a read-config verify pass.
module rf_config_master
   import rf_cfg_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH      = 8,
   parameter logic [DATA_WIDTH-1:0] HEAD_SAVE       = 8'hC0,
   parameter logic [DATA_WIDTH-1:0] HEAD_TEMP       = 8'hC2,
   parameter logic [DATA_WIDTH-1:0] RET_CONFIG_CMD  = 8'hC1,
   parameter logic [DATA_WIDTH-1:0] RET_VERSION_CMD = 8'hC3,
   parameter logic [DATA_WIDTH-1:0] RESET_CMD       = 8'hC4,
   parameter int unsigned          AUX_TIMEOUT     = 65535,
   parameter int unsigned          RESP_TIMEOUT    = 65535,
   parameter int unsigned          MODE_SETTLE     = 64
) (
   input  logic                    internal_clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   input  logic [1:0]              cmd_op,
   input  logic                    cmd_save,
   input  logic [DATA_WIDTH-1:0]   cfg_addh,
   input  logic [DATA_WIDTH-1:0]   cfg_addl,
   input  logic [DATA_WIDTH-1:0]   cfg_sped,
   input  logic [DATA_WIDTH-1:0]   cfg_chan,
   input  logic [DATA_WIDTH-1:0]   cfg_option,
   input  logic [1:0]              normal_mode,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              err_code,
   output logic [DATA_WIDTH-1:0]   rb_head,
   output logic [DATA_WIDTH-1:0]   rb_addh,
   output logic [DATA_WIDTH-1:0]   rb_addl,
   output logic [DATA_WIDTH-1:0]   rb_sped,
   output logic [DATA_WIDTH-1:0]   rb_chan,
   output logic [DATA_WIDTH-1:0]   rb_option,
   output logic [4*DATA_WIDTH-1:0] version,
   output logic                    M0,
   output logic                    M1,
   input  logic                    AUX,
   output logic                    TX_use,
   input  logic                    TX_available,
   output logic [DATA_WIDTH-1:0]   data_to_uart,
   input  logic                    RX_flag,
   input  logic [DATA_WIDTH-1:0]   data_from_uart
);

   localparam int unsigned SW = (MODE_SETTLE < 1) ? 1 : $clog2(MODE_SETTLE + 1);

   state_e                  state_q;
   logic [1:0]              m_q, normal_q, op_q, err_q, err_code_q;
   logic                    busy_q, done_q, tx_use_q, tx_armed_q, tx_ld_q;
   logic                    save_q, post_q, vfy_q;
   logic [2:0]              idx_q, rx_idx_q;
   logic [DATA_WIDTH-1:0]   data_q, addh_q, addl_q, sped_q, chan_q, option_q;
   logic [DATA_WIDTH-1:0]   rb_head_q, rb_addh_q, rb_addl_q, rb_sped_q, rb_chan_q, rb_option_q;
   logic [4*DATA_WIDTH-1:0] version_q;
   logic                    aux_s1_q, aux_s2_q, rx_s1_q, rx_s2_q, rx_s3_q;
   logic [SW-1:0]           settle_q;

   logic                    rx_rise, in_wait, aux_stable, aux_expired, resp_expired;
   logic [1:0]              op_eff;
   logic [2:0]              tx_len, resp_len;
   logic [DATA_WIDTH-1:0]   tx_byte, wr_head;

   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         aux_s1_q <= 1'b0;
         aux_s2_q <= 1'b0;
         rx_s1_q  <= 1'b0;
         rx_s2_q  <= 1'b0;
         rx_s3_q  <= 1'b0;
         settle_q <= '0;
      end else begin
         aux_s1_q <= AUX;
         aux_s2_q <= aux_s1_q;
         rx_s1_q  <= RX_flag;
         rx_s2_q  <= rx_s1_q;
         rx_s3_q  <= rx_s2_q;
         // Counts consecutive high cycles of the synchronised AUX while waiting.
         if (!in_wait || !aux_s2_q) begin
            settle_q <= '0;
         end else if (settle_q != SW'(MODE_SETTLE)) begin
            settle_q <= settle_q + SW'(1);
         end
      end
   end

   assign rx_rise    = rx_s2_q & ~rx_s3_q;
   assign in_wait    = (state_q == ST_AUX_WAIT) || (state_q == ST_EXIT_WAIT);
   assign aux_stable = (settle_q == SW'(MODE_SETTLE));

   rf_cfg_timeout #(.MAX(AUX_TIMEOUT)) u_aux_tmo (
      .clk_i     (internal_clk),
      .rst_ni    (rst_n),
      .load_i    (!in_wait),
      .en_i      (in_wait),
      .expired_o (aux_expired)
   );

   rf_cfg_timeout #(.MAX(RESP_TIMEOUT)) u_resp_tmo (
      .clk_i     (internal_clk),
      .rst_ni    (rst_n),
      .load_i    ((state_q != ST_RESP) || rx_rise),
      .en_i      (state_q == ST_RESP),
      .expired_o (resp_expired)
   );

   // The verify pass of a write reuses the read-config frame and reply handling.
   assign op_eff   = vfy_q ? OP_RD_CFG : op_q;
   assign wr_head  = save_q ? HEAD_SAVE : HEAD_TEMP;
   assign tx_len   = (op_eff == OP_WRITE) ? LEN_WRITE : LEN_CMD;
   assign resp_len = (op_eff == OP_RD_CFG) ? LEN_RESP_CFG : LEN_RESP_VER;

   always_comb begin
      tx_byte = RESET_CMD;
      case (op_eff)
         OP_WRITE: begin
            case (idx_q)
               3'd0:    tx_byte = wr_head;
               3'd1:    tx_byte = addh_q;
               3'd2:    tx_byte = addl_q;
               3'd3:    tx_byte = sped_q;
               3'd4:    tx_byte = chan_q;
               default: tx_byte = option_q;
            endcase
         end
         OP_RD_CFG: tx_byte = RET_CONFIG_CMD;
         OP_RD_VER: tx_byte = RET_VERSION_CMD;
         default:   tx_byte = RESET_CMD;
      endcase
   end

   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         m_q         <= 2'b00;
         normal_q    <= 2'b00;
         op_q        <= OP_WRITE;
         err_q       <= ERR_OK;
         err_code_q  <= ERR_OK;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tx_use_q    <= 1'b0;
         tx_armed_q  <= 1'b1;
         tx_ld_q     <= 1'b0;
         save_q      <= 1'b0;
         post_q      <= 1'b0;
         vfy_q       <= 1'b0;
         idx_q       <= '0;
         rx_idx_q    <= '0;
         data_q      <= '0;
         addh_q      <= '0;
         addl_q      <= '0;
         sped_q      <= '0;
         chan_q      <= '0;
         option_q    <= '0;
         rb_head_q   <= '0;
         rb_addh_q   <= '0;
         rb_addl_q   <= '0;
         rb_sped_q   <= '0;
         rb_chan_q   <= '0;
         rb_option_q <= '0;
         version_q   <= '0;
      end else begin
         done_q   <= 1'b0;
         tx_use_q <= 1'b0;
         // A fresh handshake needs TX_available seen low after the previous strobe.
         if (!TX_available) tx_armed_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q       <= cmd_op;
                  save_q     <= cmd_save;
                  addh_q     <= cfg_addh;
                  addl_q     <= cfg_addl;
                  sped_q     <= cfg_sped;
                  chan_q     <= cfg_chan;
                  option_q   <= cfg_option;
                  normal_q   <= normal_mode;
                  err_q      <= ERR_OK;
                  err_code_q <= ERR_OK;
                  busy_q     <= 1'b1;
                  post_q     <= 1'b0;
                  vfy_q      <= 1'b0;
                  state_q    <= ST_ENTER;
               end
            end
            ST_ENTER: begin
               m_q     <= 2'b11;
               state_q <= ST_AUX_WAIT;
            end
            ST_AUX_WAIT: begin
               if (aux_stable) begin
                  idx_q   <= '0;
                  tx_ld_q <= 1'b0;
                  if (!post_q) begin
                     state_q <= ST_SEND;
                  end
`ifdef RF_CFG_VERIFY_EN
                  else if ((op_q == OP_WRITE) && !vfy_q) begin
                     vfy_q   <= 1'b1;
                     post_q  <= 1'b0;
                     state_q <= ST_SEND;
                  end
`endif
                  else begin
                     state_q <= ST_EXIT;
                  end
               end else if (aux_expired) begin
                  err_q   <= ERR_AUX;
                  state_q <= ST_EXIT;
               end
            end
            ST_SEND: begin
               if (!tx_ld_q) begin
                  data_q  <= tx_byte;
                  tx_ld_q <= 1'b1;
               end else if (tx_armed_q && TX_available) begin
                  tx_use_q   <= 1'b1;
                  tx_armed_q <= 1'b0;
                  tx_ld_q    <= 1'b0;
                  idx_q      <= idx_q + 3'd1;
                  if (idx_q == tx_len - 3'd1) begin
                     rx_idx_q <= '0;
                     if ((op_eff == OP_WRITE) || (op_eff == OP_RESET)) begin
                        post_q  <= 1'b1;
                        state_q <= ST_AUX_WAIT;
                     end else begin
                        state_q <= ST_RESP;
                     end
                  end
               end
            end
            ST_RESP: begin
               if (rx_rise) begin
                  if (op_eff == OP_RD_CFG) begin
                     case (rx_idx_q)
                        3'd0:    rb_head_q   <= data_from_uart;
                        3'd1:    rb_addh_q   <= data_from_uart;
                        3'd2:    rb_addl_q   <= data_from_uart;
                        3'd3:    rb_sped_q   <= data_from_uart;
                        3'd4:    rb_chan_q   <= data_from_uart;
                        default: rb_option_q <= data_from_uart;
                     endcase
                  end else begin
                     case (rx_idx_q[1:0])
                        2'd0:    version_q[4*DATA_WIDTH-1 -: DATA_WIDTH] <= data_from_uart;
                        2'd1:    version_q[3*DATA_WIDTH-1 -: DATA_WIDTH] <= data_from_uart;
                        2'd2:    version_q[2*DATA_WIDTH-1 -: DATA_WIDTH] <= data_from_uart;
                        default: version_q[DATA_WIDTH-1 -: DATA_WIDTH]   <= data_from_uart;
                     endcase
                  end
                  rx_idx_q <= rx_idx_q + 3'd1;
                  if (rx_idx_q == resp_len - 3'd1) state_q <= ST_CHECK;
               end else if (resp_expired) begin
                  err_q   <= ERR_RESP;
                  state_q <= ST_EXIT;
               end
            end
            ST_CHECK: begin
               if ((op_eff == OP_RD_CFG) && (rb_head_q != HEAD_SAVE) && (rb_head_q != HEAD_TEMP))
                  err_q <= ERR_MISMATCH;
               if ((op_eff == OP_RD_VER) && (version_q[4*DATA_WIDTH-1 -: DATA_WIDTH] != RET_VERSION_CMD))
                  err_q <= ERR_MISMATCH;
`ifdef RF_CFG_VERIFY_EN
               if (vfy_q && ({rb_head_q, rb_addh_q, rb_addl_q, rb_sped_q, rb_chan_q, rb_option_q} !=
                             {wr_head, addh_q, addl_q, sped_q, chan_q, option_q}))
                  err_q <= ERR_MISMATCH;
`endif
               state_q <= ST_EXIT;
            end
            ST_EXIT: begin
               m_q     <= normal_q;
               state_q <= ST_EXIT_WAIT;
            end
            ST_EXIT_WAIT: begin
               if (aux_stable) begin
                  state_q <= ST_DONE;
               end else if (aux_expired) begin
                  if (err_q == ERR_OK) err_q <= ERR_AUX;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               err_code_q <= err_q;
               state_q    <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign M0           = m_q[0];
   assign M1           = m_q[1];
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_code     = err_code_q;
   assign TX_use       = tx_use_q;
   assign data_to_uart = data_q;
   assign rb_head      = rb_head_q;
   assign rb_addh      = rb_addh_q;
   assign rb_addl      = rb_addl_q;
   assign rb_sped      = rb_sped_q;
   assign rb_chan      = rb_chan_q;
   assign rb_option    = rb_option_q;
   assign version      = version_q;

endmodule
